// File: rtl/uart_frame_pkg.sv
`default_nettype none
// ============================================================================
// Package  : uart_frame_pkg
// Brief    : Shared types and constants for the UART frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
package uart_frame_pkg;

   localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

   typedef enum logic [2:0] {
      HUNT    = 3'd0,
      CMD     = 3'd1,
      LEN     = 3'd2,
      PAYLOAD = 3'd3,
      CHK     = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_CHK     = 2'd1,
      ERR_LEN     = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

endpackage
`default_nettype wire

// File: rtl/uart_frame_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface : uart_frame_decoder_if
// Brief     : Received-byte input and decoded-frame outputs of the decoder.
//             Statistics signals exist only with UART_FRAME_STATS_EN.
// Revision  : 1.0 - initial release
// ============================================================================
interface uart_frame_decoder_if;

   logic       rx_byte_valid;
   logic [7:0] rx_byte_data;
   logic [7:0] frame_cmd;
   logic [7:0] frame_len;
   logic       pl_valid;
   logic [7:0] pl_data;
   logic [7:0] pl_index;
   logic       frame_done;
   logic       frame_ok;
   logic [1:0] err_code;
   logic       frame_active;
`ifdef UART_FRAME_STATS_EN
   logic [15:0] stat_ok_cnt;
   logic [15:0] stat_err_cnt;
   logic [15:0] stat_drop_cnt;
`endif

`ifdef UART_FRAME_STATS_EN
   modport master (
      output rx_byte_valid, rx_byte_data,
      input  frame_cmd, frame_len, pl_valid, pl_data, pl_index,
      input  frame_done, frame_ok, err_code, frame_active,
      input  stat_ok_cnt, stat_err_cnt, stat_drop_cnt
   );
   modport slave (
      input  rx_byte_valid, rx_byte_data,
      output frame_cmd, frame_len, pl_valid, pl_data, pl_index,
      output frame_done, frame_ok, err_code, frame_active,
      output stat_ok_cnt, stat_err_cnt, stat_drop_cnt
   );
`else
   modport master (
      output rx_byte_valid, rx_byte_data,
      input  frame_cmd, frame_len, pl_valid, pl_data, pl_index,
      input  frame_done, frame_ok, err_code, frame_active
   );
   modport slave (
      input  rx_byte_valid, rx_byte_data,
      output frame_cmd, frame_len, pl_valid, pl_data, pl_index,
      output frame_done, frame_ok, err_code, frame_active
   );
`endif

endinterface
`default_nettype wire

// File: rtl/uart_frame_timeout.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_timeout
// Brief    : Clearable, enabled up-counter that flags expiry at TIMEOUT_CLKS.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_timeout #(
   parameter int TIMEOUT_CLKS = 34720
) (
   input  wire clk,
   input  wire rst,
   input  wire clr,
   input  wire en,
   output wire expired
);

   localparam int              c_W     = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [c_W-1:0]  c_LIMIT = c_W'(TIMEOUT_CLKS);
   localparam logic [c_W-1:0]  c_ONE   = c_W'(1);

   logic [c_W-1:0] r_cnt;

   // Idle (disabled) time never accumulates; the count parks at the limit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr || !en) begin
         r_cnt <= '0;
      end else if (r_cnt != c_LIMIT) begin
         r_cnt <= r_cnt + c_ONE;
      end
   end

   assign expired = en && (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_decoder
// Brief    : Hunts SYNC,CMD,LEN,payload,CHK frames in a UART byte stream,
//            streams payload and reports status. Option: UART_FRAME_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_frame_decoder
   import uart_frame_pkg::*;
#(
   parameter int         MAX_LEN      = 16,
   parameter int         TIMEOUT_CLKS = 34720,
   parameter logic [7:0] SYNC_BYTE    = c_SYNC_BYTE_DEFAULT
) (
   input  wire                  clk,
   input  wire                  rst,
   uart_frame_decoder_if.slave  bus
);

   localparam logic [7:0] c_MAX_LEN = 8'(MAX_LEN);

   state_t     r_state, w_state_next;
   logic       r_valid_d;
   logic [7:0] r_sum, w_sum_next;
   logic [7:0] r_cnt, w_cnt_next;
   logic [7:0] r_frame_cmd, w_frame_cmd_next;
   logic [7:0] r_frame_len, w_frame_len_next;
   logic       r_pl_valid, w_pl_valid_next;
   logic [7:0] r_pl_data, w_pl_data_next;
   logic [7:0] r_pl_index, w_pl_index_next;
   logic       r_frame_done, w_frame_done_next;
   logic       r_frame_ok, w_frame_ok_next;
   err_code_t  r_err_code, w_err_code_next;
   logic       w_drop;
   logic       w_accept;
   logic       w_expired;
   logic       w_timer_en;
   logic [7:0] w_byte;
   logic [7:0] w_cnt_inc;

   assign w_byte     = bus.rx_byte_data;
   assign w_accept   = bus.rx_byte_valid && !r_valid_d;
   assign w_timer_en = (r_state != HUNT);
   assign w_cnt_inc  = r_cnt + 8'd1;

   uart_frame_timeout #(
      .TIMEOUT_CLKS (TIMEOUT_CLKS)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clr     (w_accept),
      .en      (w_timer_en),
      .expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= HUNT;
         r_valid_d    <= 1'b0;
         r_sum        <= '0;
         r_cnt        <= '0;
         r_frame_cmd  <= '0;
         r_frame_len  <= '0;
         r_pl_valid   <= 1'b0;
         r_pl_data    <= '0;
         r_pl_index   <= '0;
         r_frame_done <= 1'b0;
         r_frame_ok   <= 1'b0;
         r_err_code   <= ERR_NONE;
      end else begin
         r_state      <= w_state_next;
         r_valid_d    <= bus.rx_byte_valid;
         r_sum        <= w_sum_next;
         r_cnt        <= w_cnt_next;
         r_frame_cmd  <= w_frame_cmd_next;
         r_frame_len  <= w_frame_len_next;
         r_pl_valid   <= w_pl_valid_next;
         r_pl_data    <= w_pl_data_next;
         r_pl_index   <= w_pl_index_next;
         r_frame_done <= w_frame_done_next;
         r_frame_ok   <= w_frame_ok_next;
         r_err_code   <= w_err_code_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_sum_next        = r_sum;
      w_cnt_next        = r_cnt;
      w_frame_cmd_next  = r_frame_cmd;
      w_frame_len_next  = r_frame_len;
      w_pl_valid_next   = 1'b0;
      w_pl_data_next    = r_pl_data;
      w_pl_index_next   = r_pl_index;
      w_frame_done_next = 1'b0;
      w_frame_ok_next   = r_frame_ok;
      w_err_code_next   = r_err_code;
      w_drop            = 1'b0;

      // An accepted byte outranks a timeout expiring in the same cycle.
      if (w_accept) begin
         case (r_state)
            HUNT: begin
               if (w_byte == SYNC_BYTE) begin
                  w_state_next = CMD;
               end else begin
                  w_drop = 1'b1;
               end
            end
            CMD: begin
               w_frame_cmd_next = w_byte;
               w_sum_next       = w_byte;
               w_state_next     = LEN;
            end
            LEN: begin
               w_frame_len_next = w_byte;
               w_sum_next       = r_sum + w_byte;
               w_cnt_next       = '0;
               if (w_byte > c_MAX_LEN) begin
                  w_frame_done_next = 1'b1;
                  w_frame_ok_next   = 1'b0;
                  w_err_code_next   = ERR_LEN;
                  w_state_next      = HUNT;
               end else if (w_byte == 8'd0) begin
                  w_state_next = CHK;
               end else begin
                  w_state_next = PAYLOAD;
               end
            end
            PAYLOAD: begin
               w_pl_valid_next = 1'b1;
               w_pl_data_next  = w_byte;
               w_pl_index_next = r_cnt;
               w_sum_next      = r_sum + w_byte;
               w_cnt_next      = w_cnt_inc;
               if (w_cnt_inc == r_frame_len) begin
                  w_state_next = CHK;
               end
            end
            CHK: begin
               w_frame_done_next = 1'b1;
               w_frame_ok_next   = (w_byte == r_sum);
               w_err_code_next   = (w_byte == r_sum) ? ERR_NONE : ERR_CHK;
               w_state_next      = HUNT;
            end
            default: begin
               w_state_next = HUNT;
            end
         endcase
      end else if (w_expired) begin
         w_frame_done_next = 1'b1;
         w_frame_ok_next   = 1'b0;
         w_err_code_next   = ERR_TIMEOUT;
         w_state_next      = HUNT;
      end
   end

   assign bus.frame_cmd    = r_frame_cmd;
   assign bus.frame_len    = r_frame_len;
   assign bus.pl_valid     = r_pl_valid;
   assign bus.pl_data      = r_pl_data;
   assign bus.pl_index     = r_pl_index;
   assign bus.frame_done   = r_frame_done;
   assign bus.frame_ok     = r_frame_ok;
   assign bus.err_code     = r_err_code;
   assign bus.frame_active = (r_state != HUNT);

`ifdef UART_FRAME_STATS_EN
   logic [15:0] r_stat_ok, r_stat_err, r_stat_drop;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_ok   <= '0;
         r_stat_err  <= '0;
         r_stat_drop <= '0;
      end else begin
         if (w_frame_done_next && w_frame_ok_next && (r_stat_ok != 16'hFFFF)) begin
            r_stat_ok <= r_stat_ok + 16'd1;
         end
         if (w_frame_done_next && !w_frame_ok_next && (r_stat_err != 16'hFFFF)) begin
            r_stat_err <= r_stat_err + 16'd1;
         end
         if (w_drop && (r_stat_drop != 16'hFFFF)) begin
            r_stat_drop <= r_stat_drop + 16'd1;
         end
      end
   end

   assign bus.stat_ok_cnt   = r_stat_ok;
   assign bus.stat_err_cnt  = r_stat_err;
   assign bus.stat_drop_cnt = r_stat_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_decoder
// Brief    : Self-checking bench: table vectors, corner sequences and random
//            frames against a byte-stream parsing model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_frame_decoder;

   localparam int         MAX_LEN      = 16;
   localparam int         TIMEOUT_CLKS = 200;
   localparam logic [7:0] SYNC         = 8'hA5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_frame_decoder_if bus ();

   uart_frame_decoder #(
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_CLKS (TIMEOUT_CLKS),
      .SYNC_BYTE    (SYNC)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [7:0] data;
      logic [7:0] index;
   } pl_ev_t;

   typedef struct packed {
      logic       ok;
      logic [1:0] err;
      logic [7:0] cmd;
      logic [7:0] len;
      logic       active;
   } done_ev_t;

   typedef logic [7:0] byte_q_t[$];

   typedef struct {
      logic [63:0] bytes;
      int          n;
      logic        ok;
      logic [1:0]  err;
      int          npl;
      logic [7:0]  cmd;
      logic [7:0]  len;
   } vec_t;

   pl_ev_t   got_pl[$], exp_pl[$];
   done_ev_t got_done[$], exp_done[$];
   int n_checks = 0;
   int n_errors = 0;
   int m_ok = 0, m_err = 0, m_drop = 0;

   always @(negedge clk) begin
      pl_ev_t   p;
      done_ev_t d;
      if (bus.pl_valid) begin
         p.data  = bus.pl_data;
         p.index = bus.pl_index;
         got_pl.push_back(p);
      end
      if (bus.frame_done) begin
         d.ok     = bus.frame_ok;
         d.err    = bus.err_code;
         d.cmd    = bus.frame_cmd;
         d.len    = bus.frame_len;
         d.active = bus.frame_active;
         got_done.push_back(d);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: walk the byte list frame by frame using the framing rules.
   task automatic model(input byte_q_t q);
      int         i = 0;
      logic [7:0] sum;
      pl_ev_t     p;
      done_ev_t   d;
      while (i < q.size()) begin
         if (q[i] != SYNC) begin
            m_drop++;
            i++;
            continue;
         end
         d.cmd    = q[i+1];
         d.len    = q[i+2];
         d.active = 1'b0;
         i += 3;
         if (int'(d.len) > MAX_LEN) begin
            d.ok  = 1'b0;
            d.err = 2'd2;
            m_err++;
            exp_done.push_back(d);
            continue;
         end
         sum = d.cmd + d.len;
         for (int k = 0; k < int'(d.len); k++) begin
            p.data  = q[i];
            p.index = 8'(k);
            exp_pl.push_back(p);
            sum = sum + q[i];
            i++;
         end
         d.ok  = (q[i] == sum);
         d.err = d.ok ? 2'd0 : 2'd1;
         if (d.ok) m_ok++; else m_err++;
         i++;
         exp_done.push_back(d);
      end
   endtask

   task automatic clear_q();
      got_pl.delete();
      exp_pl.delete();
      got_done.delete();
      exp_done.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
      bus.rx_byte_data  = b;
      bus.rx_byte_valid = 1'b1;
      repeat (hold) @(posedge clk);
      #1;
      bus.rx_byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
   endtask

   task automatic feed(input byte_q_t q, input bit rnd);
      foreach (q[i]) begin
         send_byte(q[i], rnd ? int'($urandom_range(1, 3)) : 1,
                         rnd ? int'($urandom_range(1, 3)) : 2);
      end
   endtask

   task automatic settle();
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic compare(input string tag);
      check({tag, " done count"}, got_done.size(), exp_done.size());
      for (int i = 0; i < exp_done.size() && i < got_done.size(); i++) begin
         check({tag, " done fields"}, 32'(got_done[i]), 32'(exp_done[i]));
      end
      check({tag, " payload count"}, got_pl.size(), exp_pl.size());
      for (int i = 0; i < exp_pl.size() && i < got_pl.size(); i++) begin
         check({tag, " payload byte"}, 32'(got_pl[i]), 32'(exp_pl[i]));
      end
   endtask

   task automatic check_stats(input string tag);
`ifdef UART_FRAME_STATS_EN
      check({tag, " stat_ok_cnt"},   bus.stat_ok_cnt,   m_ok);
      check({tag, " stat_err_cnt"},  bus.stat_err_cnt,  m_err);
      check({tag, " stat_drop_cnt"}, bus.stat_drop_cnt, m_drop);
`else
      check({tag, " frame_active idle"}, bus.frame_active, 0);
`endif
   endtask

   function automatic vec_t mk(input logic [63:0] b, input int n, input logic ok,
                               input logic [1:0] err, input int npl,
                               input logic [7:0] cmd, input logic [7:0] len);
      vec_t v;
      v.bytes = b; v.n = n; v.ok = ok; v.err = err; v.npl = npl; v.cmd = cmd; v.len = len;
      return v;
   endfunction

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t       tbl[7];
      byte_q_t    q;
      int         waited;
      logic [7:0] sum;
      int         kind;
      int         len;

      bus.rx_byte_valid = 1'b0;
      bus.rx_byte_data  = 8'h00;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);

      check("reset frame_active", bus.frame_active, 0);
      check("reset frame_cmd",    bus.frame_cmd,    0);
      check("reset frame_len",    bus.frame_len,    0);
      check("reset pl_valid",     bus.pl_valid,     0);
      check("reset pl_data",      bus.pl_data,      0);
      check("reset pl_index",     bus.pl_index,     0);
      check("reset frame_done",   bus.frame_done,   0);
      check("reset frame_ok",     bus.frame_ok,     0);
      check("reset err_code",     bus.err_code,     0);
      check_stats("reset");

      tbl[0] = mk(64'hA5_01_02_10_20_33_00_00, 6, 1'b1, 2'd0, 2, 8'h01, 8'h02);
      tbl[1] = mk(64'hA5_01_02_10_20_34_00_00, 6, 1'b0, 2'd1, 2, 8'h01, 8'h02);
      tbl[2] = mk(64'hA5_05_00_05_00_00_00_00, 4, 1'b1, 2'd0, 0, 8'h05, 8'h00);
      tbl[3] = mk(64'hA5_07_20_00_00_00_00_00, 3, 1'b0, 2'd2, 0, 8'h07, 8'h20);
      tbl[4] = mk(64'hA5_01_01_AA_AC_00_00_00, 5, 1'b1, 2'd0, 1, 8'h01, 8'h01);
      tbl[5] = mk(64'h00_FF_A5_01_01_A5_A7_00, 7, 1'b1, 2'd0, 1, 8'h01, 8'h01);
      tbl[6] = mk(64'hA5_A5_00_A5_00_00_00_00, 4, 1'b1, 2'd0, 0, 8'hA5, 8'h00);

      for (int v = 0; v < 7; v++) begin
         q = {};
         for (int k = 0; k < tbl[v].n; k++) q.push_back(tbl[v].bytes[63-8*k -: 8]);
         clear_q();
         model(q);
         feed(q, 1'b0);
         settle();
         check($sformatf("vec%0d done count", v), got_done.size(), 1);
         if (got_done.size() > 0) begin
            check($sformatf("vec%0d frame_ok", v),     got_done[0].ok,     tbl[v].ok);
            check($sformatf("vec%0d err_code", v),     got_done[0].err,    tbl[v].err);
            check($sformatf("vec%0d frame_cmd", v),    got_done[0].cmd,    tbl[v].cmd);
            check($sformatf("vec%0d frame_len", v),    got_done[0].len,    tbl[v].len);
            check($sformatf("vec%0d frame_active", v), got_done[0].active, 0);
         end
         check($sformatf("vec%0d payload count", v), got_pl.size(), tbl[v].npl);
         compare($sformatf("vec%0d model", v));
      end
      check_stats("table");

      // A strobe held high for five cycles must yield a single SYNC.
      clear_q();
      q = {8'hA5, 8'h01, 8'h01, 8'h55, 8'h57};
      model(q);
      send_byte(8'hA5, 5, 2);
      for (int k = 1; k < 5; k++) send_byte(q[k], 1, 2);
      settle();
      compare("held strobe");

      // Inter-byte timeout mid-payload.
      clear_q();
      q = {8'hA5, 8'h01, 8'h03, 8'h11};
      feed(q, 1'b0);
      waited = 0;
      while (!bus.frame_done && waited < 3 * TIMEOUT_CLKS) begin
         @(negedge clk);
         waited++;
      end
      check("timeout frame_done seen", bus.frame_done, 1);
      check("timeout err_code",        bus.err_code, 3);
      check("timeout frame_ok",        bus.frame_ok, 0);
      check("timeout frame_active",    bus.frame_active, 0);
      check("timeout delay window",
            32'((waited >= TIMEOUT_CLKS - 10) && (waited <= TIMEOUT_CLKS + 10)), 1);
      m_err++;
      settle();
      check("timeout payload count", got_pl.size(), 1);
      if (got_pl.size() > 0) check("timeout payload byte", 32'(got_pl[0]), 32'(16'h1100));
      check("timeout err_code holds", bus.err_code, 3);
      check("timeout frame_cmd holds", bus.frame_cmd, 8'h01);
      check_stats("timeout");

      // Randomised frames, garbage prefixes and jittered strobes.
      for (int f = 0; f < 25; f++) begin
         q = {};
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            sum = 8'($urandom_range(0, 255));
            q.push_back((sum == SYNC) ? 8'h00 : sum);
         end
         kind = $urandom_range(0, 3);
         q.push_back(SYNC);
         q.push_back(8'($urandom_range(0, 255)));
         len = (kind == 3) ? $urandom_range(MAX_LEN + 1, 255) : $urandom_range(0, MAX_LEN);
         q.push_back(8'(len));
         if (kind != 3) begin
            sum = q[q.size()-2] + q[q.size()-1];
            for (int k = 0; k < len; k++) begin
               q.push_back(8'($urandom_range(0, 255)));
               sum = sum + q[q.size()-1];
            end
            q.push_back((kind == 2) ? sum + 8'd1 : sum);
         end
         clear_q();
         model(q);
         feed(q, 1'b1);
         settle();
         compare($sformatf("rand%0d", f));
      end
      check_stats("random");

      // Reset in the middle of a payload: silent return to idle.
      clear_q();
      q = {8'hA5, 8'h01, 8'h03, 8'h11, 8'h22};
      feed(q, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      m_ok = 0; m_err = 0; m_drop = 0;
      @(negedge clk);
      check("midreset no frame_done", got_done.size(), 0);
      check("midreset frame_active",  bus.frame_active, 0);
      check("midreset frame_cmd",     bus.frame_cmd, 0);
      check("midreset frame_len",     bus.frame_len, 0);
      check("midreset pl_index",      bus.pl_index, 0);
      check_stats("midreset");

      clear_q();
      q = {8'hA5, 8'h01, 8'h01, 8'hA5, 8'hA7};
      model(q);
      feed(q, 1'b0);
      settle();
      compare("post reset");
      check_stats("post reset");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
